// File: rtl/led_scan_receiver_if.sv
// Scan-bus side of the LED-matrix receiver: raw 36-bit scan word and enable in, rebuilt frames and status out.
interface led_scan_receiver_if;
  logic [35:0]       scan_in;
  logic              enable;
  logic [15:0][15:0] RedPixels;
  logic [15:0][15:0] GrnPixels;
  logic              frame_valid;
  logic [7:0]        frame_count;
  logic              row_err;
  logic              busy;

  modport master (
    output scan_in, enable,
    input  RedPixels, GrnPixels, frame_valid, frame_count, row_err, busy
  );

  modport slave (
    input  scan_in, enable,
    output RedPixels, GrnPixels, frame_valid, frame_count, row_err, busy
  );
endinterface

// File: rtl/led_scan_receiver.sv
// Rebuilds 16x16 red/green frames from the row-multiplexed scan bus; a row is taken once its address has dwelt SETTLE extra cycles.
// Frame commits one cycle after the row-15 capture; no backpressure, the scan stream is free-running.
module led_scan_receiver #(
  parameter int SETTLE = 2,
  parameter int ROWS   = 16
) (
  input logic               clk,
  input logic               RST,
  led_scan_receiver_if.slave bus
);

  localparam logic [0:0] ST_SYNC  = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
  localparam logic [3:0] DWELL_MX = 4'(SETTLE);
  localparam logic [3:0] DWELL_CP = 4'(SETTLE - 1);

  logic [35:0]       r_s_q;
  logic [3:0]        r_dwell;
  logic [0:0]        r_state;
  logic [3:0]        r_expected;
  logic              r_commit;
  logic [15:0][15:0] r_shd_red;
  logic [15:0][15:0] r_shd_grn;
  logic [15:0][15:0] r_red;
  logic [15:0][15:0] r_grn;
  logic              r_frame_vld;
  logic [7:0]        r_frame_cnt;
  logic              r_row_err;

  logic [3:0] w_row_in;
  logic [3:0] w_row_q;
  logic       w_same_row;
  logic       w_cap;

  assign w_row_in   = bus.scan_in[35:32];
  assign w_row_q    = r_s_q[35:32];
  assign w_same_row = (w_row_in == w_row_q);
  // Capture on the single edge where the dwell counter climbs to SETTLE.
  assign w_cap      = bus.enable && w_same_row && (r_dwell == DWELL_CP);

  always_ff @(posedge clk) begin
    if (RST) begin
      r_s_q       <= '0;
      r_dwell     <= '0;
      r_state     <= ST_SYNC;
      r_expected  <= '0;
      r_commit    <= 1'b0;
      r_shd_red   <= '0;
      r_shd_grn   <= '0;
      r_red       <= '0;
      r_grn       <= '0;
      r_frame_vld <= 1'b0;
      r_frame_cnt <= '0;
      r_row_err   <= 1'b0;
    end else begin
      r_s_q       <= bus.scan_in;
      r_frame_vld <= 1'b0;
      if (!bus.enable) begin
        r_state    <= ST_SYNC;
        r_dwell    <= '0;
        r_commit   <= 1'b0;
        r_expected <= '0;
      end else begin
        if (!w_same_row) begin
          r_dwell <= '0;
        end else if (r_dwell != DWELL_MX) begin
          r_dwell <= r_dwell + 4'd1;
        end

        if (r_commit) begin
          r_red       <= r_shd_red;
          r_grn       <= r_shd_grn;
          r_frame_vld <= 1'b1;
          r_frame_cnt <= r_frame_cnt + 8'd1;
          r_commit    <= 1'b0;
          r_state     <= ST_SYNC;
        end

        if (w_cap) begin
          if (r_state == ST_SYNC) begin
            if (w_row_q == 4'd0) begin
              r_shd_red[0] <= r_s_q[15:0];
              r_shd_grn[0] <= r_s_q[31:16];
              r_expected   <= 4'd1;
              r_state      <= ST_RUN;
            end
          end else if (w_row_q == r_expected) begin
            r_shd_red[w_row_q] <= r_s_q[15:0];
            r_shd_grn[w_row_q] <= r_s_q[31:16];
            if (w_row_q == LAST_ROW) begin
              r_commit <= 1'b1;
            end else begin
              r_expected <= r_expected + 4'd1;
            end
          end else begin
            // Out-of-order row: a fresh row 0 restarts the frame, anything else resynchronises.
            r_row_err <= 1'b1;
            if (w_row_q == 4'd0) begin
              r_shd_red[0] <= r_s_q[15:0];
              r_shd_grn[0] <= r_s_q[31:16];
              r_expected   <= 4'd1;
            end else begin
              r_state <= ST_SYNC;
            end
          end
        end
      end
    end
  end

  assign bus.RedPixels   = r_red;
  assign bus.GrnPixels   = r_grn;
  assign bus.frame_valid = r_frame_vld;
  assign bus.frame_count = r_frame_cnt;
  assign bus.row_err     = r_row_err;
  assign bus.busy        = (r_state == ST_RUN);

endmodule

// File: tb/tb_led_scan_receiver.sv
// Bench for led_scan_receiver: directed frames plus randomized scan streams against a row-list frame model.
module tb_led_scan_receiver;
  localparam int S = 2;

  logic clk = 1'b0;
  logic RST = 1'b1;
  always #5 clk = ~clk;

  led_scan_receiver_if bus();

  led_scan_receiver #(.SETTLE(S), .ROWS(16)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  int fv_seen = 0;

  // Reference model: frames are lists of captured rows, a row is taken after S+1 cycles on the bus.
  logic [15:0][15:0] m_red, m_grn, s_red, s_grn;
  int   m_rows;
  bit   m_pend, m_fv, m_err;
  logic [7:0] m_cnt;
  int   m_prev, m_run;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_edge();
    int row;
    bit cap;
    row = int'(bus.scan_in[35:32]);
    cap = 1'b0;
    if (RST) begin
      m_red = '0; m_grn = '0; s_red = '0; s_grn = '0;
      m_rows = -1; m_pend = 0; m_fv = 0; m_err = 0; m_cnt = '0;
      m_prev = 0; m_run = 1;
    end else begin
      m_fv = 0;
      if (!bus.enable) begin
        m_rows = -1; m_pend = 0; m_prev = row; m_run = 1;
      end else begin
        if (m_pend) begin
          m_red = s_red; m_grn = s_grn; m_fv = 1; m_cnt = m_cnt + 8'd1;
          m_pend = 0; m_rows = -1;
        end
        if (row == m_prev) begin
          if (m_run <= S) begin
            m_run++;
            cap = (m_run == S + 1);
          end
        end else begin
          m_run = 1; m_prev = row;
        end
        if (cap) begin
          if (row == 0) begin
            if (m_rows >= 0) m_err = 1;
            s_red[0] = bus.scan_in[15:0]; s_grn[0] = bus.scan_in[31:16];
            m_rows = 1;
          end else if (m_rows >= 0) begin
            if (row == m_rows) begin
              s_red[row] = bus.scan_in[15:0]; s_grn[row] = bus.scan_in[31:16];
              m_rows++;
              if (m_rows == 16) m_pend = 1;
            end else begin
              m_err = 1; m_rows = -1;
            end
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (bus.frame_valid === 1'b1) fv_seen++;
    check("frame_valid", bus.frame_valid, m_fv);
    check("busy", bus.busy, (m_rows >= 0));
    check("frame_count", bus.frame_count, m_cnt);
    check("row_err", bus.row_err, m_err);
    check("red_frame", bus.RedPixels, m_red);
    check("grn_frame", bus.GrnPixels, m_grn);
  endtask

  task automatic seg(input logic [3:0] row, input logic [15:0] red, input logic [15:0] grn, input int n);
    bus.scan_in = {row, grn, red};
    repeat (n) step();
  endtask

  task automatic clean_frame(input int dw);
    for (int r = 0; r < 16; r++) seg(4'(r), 16'h0001 << r, ~(16'h0001 << r), dw);
  endtask

  task automatic reset_dut();
    RST = 1'b1;
    bus.enable = 1'b1;
    bus.scan_in = {4'hF, 32'h0};
    repeat (2) step();
    RST = 1'b0;
  endtask

  logic [15:0][15:0] e_red, e_grn;
  int idx, fv0, mode, bad_row, dw;

  initial begin
    for (int r = 0; r < 16; r++) begin
      e_red[r] = 16'h0001 << r;
      e_grn[r] = ~(16'h0001 << r);
    end
    reset_dut();
    check("rst_count", bus.frame_count, 8'd0);
    check("rst_err", bus.row_err, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_red", bus.RedPixels, 256'd0);

    // Clean frame and commit latency from first appearance of row 15
    for (int r = 0; r < 15; r++) seg(4'(r), 16'h0001 << r, ~(16'h0001 << r), 4);
    bus.scan_in = {4'd15, 16'h7FFF, 16'h8000};
    idx = 0;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (bus.frame_valid === 1'b1 && idx == 0) idx = k;
    end
    check("commit_latency", idx, 4);
    check("clean_red", bus.RedPixels, e_red);
    check("clean_grn", bus.GrnPixels, e_grn);
    check("clean_count", bus.frame_count, 8'd1);
    check("clean_err", bus.row_err, 1'b0);

    // 300 back-to-back frames, counter wraps
    reset_dut();
    fv0 = fv_seen;
    repeat (300) clean_frame(4);
    check("b2b_pulses", fv_seen - fv0, 300);
    check("b2b_count", bus.frame_count, 8'd44);
    check("b2b_err", bus.row_err, 1'b0);

    // Skipped row 7
    reset_dut();
    fv0 = fv_seen;
    for (int r = 0; r < 16; r++) if (r != 7) seg(4'(r), 16'h0001 << r, ~(16'h0001 << r), 4);
    check("skip_err", bus.row_err, 1'b1);
    check("skip_pulses", fv_seen - fv0, 0);
    check("skip_busy", bus.busy, 1'b0);
    clean_frame(4);
    check("skip_next_count", bus.frame_count, 8'd1);
    check("skip_next_err", bus.row_err, 1'b1);

    // Short dwell on row 9, then the same with the minimum dwell
    for (int pass = 0; pass < 2; pass++) begin
      reset_dut();
      fv0 = fv_seen;
      for (int r = 0; r < 16; r++)
        seg(4'(r), 16'h0001 << r, ~(16'h0001 << r), (r == 9) ? (pass == 0 ? S : S + 1) : 4);
      check("dwell_pulses", fv_seen - fv0, pass);
      check("dwell_err", bus.row_err, (pass == 0));
      check("dwell_count", bus.frame_count, 8'(pass));
    end

    // Mid-dwell data change on row 4
    reset_dut();
    for (int r = 0; r < 16; r++) begin
      if (r == 4) begin
        seg(4'd4, 16'hAAAA, ~16'h0010, 3);
        seg(4'd4, 16'h5555, 16'h1234, 3);
      end else begin
        seg(4'(r), 16'h0001 << r, ~(16'h0001 << r), 4);
      end
    end
    check("middwell_row4", bus.RedPixels[4], 16'hAAAA);
    check("middwell_grn", bus.GrnPixels, e_grn);

    // enable dropped during row 8: prior frame held
    for (int r = 0; r < 8; r++) seg(4'(r), 16'hFFFF, 16'hFFFF, 4);
    seg(4'd8, 16'hFFFF, 16'hFFFF, 2);
    bus.enable = 1'b0;
    seg(4'd8, 16'hFFFF, 16'hFFFF, 3);
    bus.enable = 1'b1;
    check("en_hold_row4", bus.RedPixels[4], 16'hAAAA);
    check("en_hold_count", bus.frame_count, 8'd1);
    clean_frame(4);
    check("en_next_red", bus.RedPixels, e_red);
    check("en_next_count", bus.frame_count, 8'd2);

    // RST during row 12
    fv0 = fv_seen;
    for (int r = 0; r < 12; r++) seg(4'(r), 16'hF0F0, 16'h0F0F, 4);
    seg(4'd12, 16'hF0F0, 16'h0F0F, 2);
    RST = 1'b1;
    repeat (2) step();
    RST = 1'b0;
    check("rst_mid_pulses", fv_seen - fv0, 0);
    check("rst_mid_red", bus.RedPixels, 256'd0);
    check("rst_mid_count", bus.frame_count, 8'd0);
    check("rst_mid_err", bus.row_err, 1'b0);
    clean_frame(4);
    check("rst_next_red", bus.RedPixels, e_red);
    check("rst_next_count", bus.frame_count, 8'd1);

    // Randomized frames with injected faults
    repeat (60) begin
      mode = $urandom_range(0, 5);
      bad_row = $urandom_range(1, 15);
      for (int r = 0; r < 16; r++) begin
        dw = $urandom_range(S + 1, S + 3);
        if (mode == 2 && r == bad_row) dw = $urandom_range(1, S);
        if (!(mode == 1 && r == bad_row)) seg(4'(r), 16'($urandom), 16'($urandom), dw);
        if (mode == 3 && r == bad_row) begin
          bus.enable = 1'b0;
          repeat ($urandom_range(1, 3)) step();
          bus.enable = 1'b1;
        end
        if (mode == 4 && r == bad_row) begin
          RST = 1'b1;
          step();
          RST = 1'b0;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/led_scan_receiver.md
Name: led_scan_receiver

Overview:
- Receiving end of the 36-bit LED-matrix scan bus that the LED driver puts on GPIO_1.
- Samples the row-multiplexed scan stream and rebuilds complete 16x16 red and green frames.
- Presents each completed frame as RedPixels/GrnPixels arrays, plus a one-cycle frame strobe and error status.
- Used as a board model in simulation, and as a loopback checker when GPIO_1 is wired back to an input header.

Parameters:
- SETTLE, 2: number of sampled cycles a row address must stay unchanged before that row's data is captured (legal range 1..15).
- ROWS, 16: rows per frame. Fixed at 16; the 4-bit row field depends on it.

Ports:
- clk, input, 1: system clock.
- RST, input, 1: synchronous, active-high reset.
- scan_in, input, 36: scan bus. Bits [35:32] are the row address, [31:16] the green row data, [15:0] the red row data. Bit c of each data field is column c.
- enable, input, 1: capture enable. While low, the block is held in SYNC.
- RedPixels, output, [15:0][15:0]: last committed red frame, indexed [row][col].
- GrnPixels, output, [15:0][15:0]: last committed green frame, indexed [row][col].
- frame_valid, output, 1: one-cycle pulse on the cycle the output frame updates.
- frame_count, output, 8: count of committed frames; wraps 255 to 0.
- row_err, output, 1: sticky flag for an out-of-order row; cleared only by RST.
- busy, output, 1: high while in RUN (a partial frame is held in the shadow buffer).

Behaviour:
- Input stage: scan_in is registered once (s_q) every clk. All decisions use s_q.
- Dwell counter:
  - Resets to 0 when s_q's row address differs from the previous s_q's row address.
  - Otherwise increments, saturating at SETTLE.
  - A row is captured on the edge where the counter reaches SETTLE, so capture happens exactly once per dwell.
  - Timing: scan_in held at row r for edges E..E+SETTLE gives capture at edge E+SETTLE. Minimum dwell is SETTLE+1 cycles.
  - Data changes later in the same dwell are ignored; the first stable capture wins.
- Capture writes s_q[31:16] into shadow green row r and s_q[15:0] into shadow red row r.
- State SYNC (reset state):
  - Captures of rows 1..15 are ignored.
  - A capture of row 0 writes shadow row 0, sets expected=1, and moves to RUN.
- State RUN:
  - Capture of row r == expected: write the shadow row and increment expected.
  - If r == 15: the next cycle copies the shadow into RedPixels/GrnPixels, pulses frame_valid for one cycle, increments frame_count, and returns to SYNC.
  - Commit latency: row-15 capture at edge E+SETTLE gives outputs and frame_valid at edge E+SETTLE+1.
  - Capture of r != expected: set row_err and discard the shadow. If r == 0, restart: write shadow row 0, set expected=1, stay in RUN. Otherwise go to SYNC.
  - A row whose dwell is too short is never captured; the next captured row then mismatches and triggers row_err.
- enable low (any cycle):
  - State forced to SYNC, shadow discarded, dwell counter cleared.
  - RedPixels/GrnPixels, frame_count and row_err hold their values.
  - A commit scheduled for the same cycle is cancelled.
- Reset values: RedPixels=0, GrnPixels=0, frame_valid=0, frame_count=0, row_err=0, busy=0, state SYNC, dwell counter 0, shadow 0.
- RST mid-frame: the partial frame is dropped and no frame_valid is produced.
- Outputs change only at commit, so the frame is never torn.
- frame_count increments by exactly 1 per frame_valid pulse.

Test Plan:
- Clean frame, SETTLE=2: rows 0..15 in order, 4 cycles each, red row r = 16'h0001<<r, green row r = ~(16'h0001<<r) -> one frame_valid pulse 3 cycles after row 15 first appears. RedPixels[r][r]=1 with all other red bits 0; GrnPixels is the complement; frame_count=1; row_err=0.
- Back-to-back frames: 300 clean frames -> 300 frame_valid pulses, frame_count=8'd44 (wrap verified), row_err=0.
- Skipped row: rows 0..6 then 8..15 -> row_err=1, no frame_valid, busy=0. A following clean frame commits with frame_count=1 and row_err still 1.
- Short dwell: row 9 held for 2 cycles (below the 3-cycle minimum) -> row 9 not captured, row_err=1 on the row-10 capture, no commit. Same stimulus with a 3-cycle dwell commits normally.
- Mid-dwell data change: row 4 holds 16'hAAAA for 3 cycles, then 16'h5555 for 3 more -> committed RedPixels[4]=16'hAAAA.
- enable dropped while row 8 is scanning, then restored with a clean frame; separately, RST asserted during row 12 -> in both cases the partial frame is discarded and outputs keep the prior frame (or zero after RST). The next clean frame commits correctly; RST clears frame_count to 0 and row_err to 0.
